// File: rtl/seg_bcd_conv_if.sv
// Display converter bus: value/radix request from the MMIO side, packed
// digit nibbles and flags towards the seven-segment scan driver.
interface seg_bcd_conv_if #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DIGITS = 4
);
    logic [DATA_W-1:0]   data_in;
    logic                jizhi_in;
    logic                load;
    logic                ready;
    logic [4*DIGITS-1:0] bcd_out;
    logic                jizhi_out;
    logic                valid;
    logic [DIGITS-1:0]   blank;

    modport master (
        output data_in, jizhi_in, load,
        input  ready, bcd_out, jizhi_out, valid, blank
    );

    modport slave (
        input  data_in, jizhi_in, load,
        output ready, bcd_out, jizhi_out, valid, blank
    );
endinterface

// File: rtl/seg_bcd_conv.sv
// seg_bcd_conv: sequential binary-to-digit converter feeding the 8-digit
// seven-segment scan driver. Decimal uses shift-and-add-3 (one bit per
// cycle); hex is a direct nibble split. Output holds the last finished
// conversion. Optional leading-zero blanking: SEG_BCD_LEADING_ZERO_BLANK_EN.
module seg_bcd_conv #(
    parameter int unsigned DATA_W = 10,
    parameter int unsigned DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst,
    seg_bcd_conv_if.slave bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + DATA_W;
    localparam int unsigned CNT_W = (DATA_W < 2) ? 1 : $clog2(DATA_W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t            state;
    logic [SR_W-1:0]   sr;
    logic [SR_W-1:0]   sr_adj;
    logic [CNT_W-1:0]  cnt;
    logic              cap_jizhi;
    logic              pend_vld;
    logic [DATA_W-1:0] pend_data;
    logic              pend_jizhi;
    logic [BCD_W-1:0]  bcd_q;
    logic              jizhi_q;
    logic              valid_q;

    logic              req_go;
    logic [DATA_W-1:0] req_data;
    logic              req_jizhi;
    logic              pend_take;

    // Initial shift register image: decimal puts the binary value below an
    // empty digit field; hex places the value directly in the digit field.
    function automatic logic [SR_W-1:0] start_image(input logic [DATA_W-1:0] d,
                                                    input logic jz);
        logic [BCD_W-1:0] ext;
        ext = '0;
        ext[DATA_W-1:0] = d;
        return jz ? {{BCD_W{1'b0}}, d} : {ext, {DATA_W{1'b0}}};
    endfunction

    // Request selection: a pending request always has priority; a fresh load
    // starts directly only in IDLE with nothing pending, otherwise it is
    // parked in the one-deep pending register (last load wins).
    always_comb begin
        req_go    = pend_vld || (state == IDLE && bus.load);
        req_data  = pend_vld ? pend_data  : bus.data_in;
        req_jizhi = pend_vld ? pend_jizhi : bus.jizhi_in;
        pend_take = bus.load && !(state == IDLE && !pend_vld);
    end

    // Add 3 to every digit field >= 5 before the next left shift.
    always_comb begin
        sr_adj = sr;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (sr[DATA_W + 4*i +: 4] >= 4'd5)
                sr_adj[DATA_W + 4*i +: 4] = sr[DATA_W + 4*i +: 4] + 4'd3;
        end
    end

    // Converter FSM with registered outputs and pending-request tracking.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            sr         <= '0;
            cnt        <= '0;
            cap_jizhi  <= 1'b1;
            pend_vld   <= 1'b0;
            pend_data  <= '0;
            pend_jizhi <= 1'b0;
            bcd_q      <= '0;
            jizhi_q    <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;

            if (pend_take) begin
                pend_vld   <= 1'b1;
                pend_data  <= bus.data_in;
                pend_jizhi <= bus.jizhi_in;
            end else if (req_go && state != SHIFT) begin
                pend_vld <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (req_go) begin
                        sr        <= start_image(req_data, req_jizhi);
                        cnt       <= '0;
                        cap_jizhi <= req_jizhi;
                        state     <= req_jizhi ? SHIFT : DONE;
                    end
                end
                SHIFT: begin
                    sr  <= {sr_adj[SR_W-2:0], 1'b0};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(DATA_W - 1))
                        state <= DONE;
                end
                DONE: begin
                    bcd_q   <= sr[SR_W-1 -: BCD_W];
                    jizhi_q <= cap_jizhi;
                    valid_q <= 1'b1;
                    if (req_go) begin
                        sr        <= start_image(req_data, req_jizhi);
                        cnt       <= '0;
                        cap_jizhi <= req_jizhi;
                        state     <= req_jizhi ? SHIFT : DONE;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEG_BCD_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_next;
    logic [DIGITS-1:0] blank_q;
    logic              hi_zero;

    // Digit i blanks when it and every higher digit are zero; digit 0 never blanks.
    always_comb begin
        blank_next = '0;
        hi_zero    = 1'b1;
        for (int unsigned i = DIGITS - 1; i >= 1; i--) begin
            hi_zero       = hi_zero && (sr[DATA_W + 4*i +: 4] == 4'd0);
            blank_next[i] = hi_zero;
        end
    end

    // Blank flags update together with bcd_out on the DONE edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            blank_q <= '0;
        else if (state == DONE)
            blank_q <= blank_next;
    end

    assign bus.blank = blank_q;
`else
    assign bus.blank = '0;
`endif

    assign bus.ready     = (state == IDLE) && !pend_vld;
    assign bus.bcd_out   = bcd_q;
    assign bus.jizhi_out = jizhi_q;
    assign bus.valid     = valid_q;
endmodule

// File: tb/tb_seg_bcd_conv.sv
// Directed self-checking bench for seg_bcd_conv (default 10-bit, 4 digits).
module tb_seg_bcd_conv;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    seg_bcd_conv_if #(.DATA_W(10), .DIGITS(4)) bus ();

    seg_bcd_conv #(.DATA_W(10), .DIGITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [9:0] d, input logic jz);
        bus.data_in  = d;
        bus.jizhi_in = jz;
        bus.load     = 1'b1;
        tick();
        bus.load     = 1'b0;
    endtask

    task automatic test_reset();
        start_load(10'h3A5, 1'b0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        tests++; if (bus.bcd_out !== 16'h0000) begin fails++; $display("FAIL rst_bcd: got %h want 0000", bus.bcd_out); end
        tests++; if (bus.jizhi_out !== 1'b1) begin fails++; $display("FAIL rst_jizhi: got %b want 1", bus.jizhi_out); end
        tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got %b want 0", bus.valid); end
        tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL rst_ready: got %b want 1", bus.ready); end
        tests++; if (bus.blank !== 4'b0000) begin fails++; $display("FAIL rst_blank: got %b want 0000", bus.blank); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_decimal_max();
        start_load(10'd1023, 1'b1);
        for (int k = 0; k < 11; k++) begin
            tests++; if (bus.ready !== 1'b0) begin fails++; $display("FAIL dmax_ready_busy[%0d]: got %b want 0", k, bus.ready); end
            tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL dmax_valid_early[%0d]: got %b want 0", k, bus.valid); end
            tests++; if (bus.bcd_out !== 16'h0000) begin fails++; $display("FAIL dmax_bcd_hold[%0d]: got %h want 0000", k, bus.bcd_out); end
            tick();
        end
        tests++; if (bus.valid !== 1'b1) begin fails++; $display("FAIL dmax_valid: got %b want 1", bus.valid); end
        tests++; if (bus.bcd_out !== 16'h1023) begin fails++; $display("FAIL dmax_bcd: got %h want 1023", bus.bcd_out); end
        tests++; if (bus.jizhi_out !== 1'b1) begin fails++; $display("FAIL dmax_jizhi: got %b want 1", bus.jizhi_out); end
        tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL dmax_ready: got %b want 1", bus.ready); end
        tick();
        tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL dmax_valid_pulse: got %b want 0", bus.valid); end
        tests++; if (bus.bcd_out !== 16'h1023) begin fails++; $display("FAIL dmax_bcd_keep: got %h want 1023", bus.bcd_out); end
    endtask

    task automatic test_hex();
        logic [3:0] exp_blank;
`ifdef SEG_BCD_LEADING_ZERO_BLANK_EN
        exp_blank = 4'b1000;
`else
        exp_blank = 4'b0000;
`endif
        start_load(10'h3A5, 1'b0);
        tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL hex_valid_early: got %b want 0", bus.valid); end
        tick();
        tests++; if (bus.valid !== 1'b1) begin fails++; $display("FAIL hex_valid: got %b want 1", bus.valid); end
        tests++; if (bus.bcd_out !== 16'h03A5) begin fails++; $display("FAIL hex_bcd: got %h want 03a5", bus.bcd_out); end
        tests++; if (bus.jizhi_out !== 1'b0) begin fails++; $display("FAIL hex_jizhi: got %b want 0", bus.jizhi_out); end
        tests++; if (bus.blank !== exp_blank) begin fails++; $display("FAIL hex_blank: got %b want %b", bus.blank, exp_blank); end
        tick();
        tests++; if (bus.valid !== 1'b0) begin fails++; $display("FAIL hex_valid_pulse: got %b want 0", bus.valid); end
        tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL hex_ready: got %b want 1", bus.ready); end
    endtask

    task automatic test_pending();
        int n;
        int extra;
        start_load(10'd500, 1'b1);
        tick();
        tick();
        start_load(10'd7, 1'b1);
        tick();
        start_load(10'd42, 1'b1);
        tests++; if (bus.ready !== 1'b0) begin fails++; $display("FAIL pend_ready: got %b want 0", bus.ready); end
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick(); n++;
            if (bus.valid === 1'b1) break;
        end
        tests++; if (n !== 6) begin fails++; $display("FAIL pend_first_lat: got %0d want 6", n); end
        tests++; if (bus.bcd_out !== 16'h0500) begin fails++; $display("FAIL pend_first_bcd: got %h want 0500", bus.bcd_out); end
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick(); n++;
            if (bus.valid === 1'b1) break;
        end
        tests++; if (n !== 11) begin fails++; $display("FAIL pend_second_lat: got %0d want 11", n); end
        tests++; if (bus.bcd_out !== 16'h0042) begin fails++; $display("FAIL pend_second_bcd: got %h want 0042", bus.bcd_out); end
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.valid === 1'b1) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL pend_extra_valid: got %0d want 0", extra); end
        tests++; if (bus.bcd_out !== 16'h0042) begin fails++; $display("FAIL pend_final_bcd: got %h want 0042", bus.bcd_out); end
    endtask

    task automatic test_reset_midop();
        int n;
        int seen;
        start_load(10'd999, 1'b1);
        tick();
        tick();
        tick();
        rst = 1'b0;
        #1;
        tests++; if (bus.ready !== 1'b1) begin fails++; $display("FAIL rmid_ready: got %b want 1", bus.ready); end
        tests++; if (bus.bcd_out !== 16'h0000) begin fails++; $display("FAIL rmid_bcd: got %h want 0000", bus.bcd_out); end
        tick();
        tick();
        rst = 1'b1;
        seen = 0;
        for (int k = 0; k < 15; k++) begin
            tick();
            if (bus.valid === 1'b1) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL rmid_no_valid: got %0d want 0", seen); end
        tests++; if (bus.bcd_out !== 16'h0000) begin fails++; $display("FAIL rmid_bcd_hold: got %h want 0000", bus.bcd_out); end
        start_load(10'd999, 1'b1);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick(); n++;
            if (bus.valid === 1'b1) break;
        end
        tests++; if (n !== 11) begin fails++; $display("FAIL rmid_reload_lat: got %0d want 11", n); end
        tests++; if (bus.bcd_out !== 16'h0999) begin fails++; $display("FAIL rmid_reload_bcd: got %h want 0999", bus.bcd_out); end
    endtask

    task automatic test_blank();
        logic [9:0]  vals [3];
        logic [15:0] exp_bcd [3];
        logic [3:0]  exp_blank [3];
        int n;
        vals = '{10'd7, 10'd0, 10'd1000};
        exp_bcd = '{16'h0007, 16'h0000, 16'h1000};
`ifdef SEG_BCD_LEADING_ZERO_BLANK_EN
        exp_blank = '{4'b1110, 4'b1110, 4'b0000};
`else
        exp_blank = '{4'b0000, 4'b0000, 4'b0000};
`endif
        for (int v = 0; v < 3; v++) begin
            start_load(vals[v], 1'b1);
            n = 0;
            for (int k = 0; k < 20; k++) begin
                tick(); n++;
                if (bus.valid === 1'b1) break;
            end
            tests++; if (bus.valid !== 1'b1) begin fails++; $display("FAIL blank_timeout[%0d]: got %0d cycles without valid", v, n); end
            tests++; if (bus.bcd_out !== exp_bcd[v]) begin fails++; $display("FAIL blank_bcd[%0d]: got %h want %h", v, bus.bcd_out, exp_bcd[v]); end
            tests++; if (bus.blank !== exp_blank[v]) begin fails++; $display("FAIL blank_flags[%0d]: got %b want %b", v, bus.blank, exp_blank[v]); end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got [$];
        for (int k = 1; k <= 3; k++) begin
            bus.data_in  = 10'(k);
            bus.jizhi_in = 1'b0;
            bus.load     = 1'b1;
            tick();
            if (bus.valid === 1'b1) got.push_back(bus.bcd_out);
        end
        bus.load = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (bus.valid === 1'b1) got.push_back(bus.bcd_out);
        end
        tests++; if (got.size() !== 3) begin fails++; $display("FAIL b2b_count: got %0d want 3", got.size()); end
        for (int k = 0; k < 3; k++) begin
            if (k < got.size()) begin
                tests++; if (got[k] !== 16'(k + 1)) begin fails++; $display("FAIL b2b_value[%0d]: got %h want %h", k, got[k], 16'(k + 1)); end
            end
        end
    endtask

    initial begin
        bus.data_in  = '0;
        bus.jizhi_in = 1'b1;
        bus.load     = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        test_reset();
        test_decimal_max();
        test_hex();
        test_pending();
        test_reset_midop();
        test_blank();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
